// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and flag bundle for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_MUL  = 4'd10;

    typedef enum logic [0:0] {
        S_IDLE,
        S_MUL
    } state_t;

    typedef struct packed {
        logic zf;
        logic cf;
        logic of;
    } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle, WIDTH cycles per product.
module alu_mul_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    logic               busy_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_step;

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    // product is the post-step value so the caller can register it on the final step edge
    assign done     = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign product  = acc_step;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (start) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
        end else if (busy_q) begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready input handshake; single-cycle ops plus an iterative multiply.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       m,
    output logic             out_valid,
    output logic [WIDTH-1:0] y,
    output logic             zf,
    output logic             cf,
    output logic             of
);

    localparam int unsigned SHW = $clog2(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   y_q, y_d;
    flags_t             flags_q, flags_d;
    logic               out_valid_q, out_valid_d;

    logic               accept;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   alu_y;
    logic               alu_cf;
    logic               alu_of;

    assign in_ready = (state_q == S_IDLE);
    assign accept   = in_valid && in_ready;

    alu_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mul_start),
        .a      (a),
        .b      (b),
        .done   (mul_done),
        .product(mul_prod)
    );

    // Single-cycle datapath; the extra top bit of sum/diff is carry-out / borrow.
    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        diff   = {1'b0, a} - {1'b0, b};
        shamt  = b[SHW-1:0];
        alu_y  = '0;
        alu_cf = 1'b0;
        alu_of = 1'b0;
        case (m)
            ALU_ADD: begin
                alu_y  = sum[WIDTH-1:0];
                alu_cf = sum[WIDTH];
                alu_of = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_y  = diff[WIDTH-1:0];
                alu_cf = diff[WIDTH];
                alu_of = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND:  alu_y = a & b;
            ALU_OR:   alu_y = a | b;
            ALU_XOR:  alu_y = a ^ b;
            ALU_SLT:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: alu_y = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_SLL:  alu_y = a << shamt;
            ALU_SRL:  alu_y = a >> shamt;
            ALU_SRA:  alu_y = $signed(a) >>> shamt;
            default:  alu_y = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        y_d         = y_q;
        flags_d     = flags_q;
        out_valid_d = 1'b0;
        mul_start   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (m == ALU_MUL) begin
                        mul_start = 1'b1;
                        state_d   = S_MUL;
                    end else begin
                        y_d         = alu_y;
                        flags_d.zf  = (alu_y == '0);
                        flags_d.cf  = alu_cf;
                        flags_d.of  = alu_of;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                if (mul_done) begin
                    y_d         = mul_prod[WIDTH-1:0];
                    flags_d.zf  = (mul_prod[WIDTH-1:0] == '0);
                    flags_d.cf  = |mul_prod[2*WIDTH-1:WIDTH];
                    flags_d.of  = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q         <= '0;
            flags_q     <= flags_t'{zf: 1'b1, cf: 1'b0, of: 1'b0};
            out_valid_q <= 1'b0;
        end else begin
            y_q         <= y_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign y         = y_q;
    assign zf        = flags_q.zf;
    assign cf        = flags_q.cf;
    assign of        = flags_q.of;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench: WIDTH=4 directed vectors and multi-cycle sequences, WIDTH=32 random stream vs a model.
module tb_alu_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH = 4 instance
    logic       rst_n4, iv4, ir4, ov4, zf4, cf4, of4;
    logic [3:0] a4, b4, m4, y4;
    // WIDTH = 32 instance
    logic        rst_n32, iv32, ir32, ov32, zf32, cf32, of32;
    logic [31:0] a32, b32, y32;
    logic [3:0]  m32;

    alu_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n4), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .m(m4),
        .out_valid(ov4), .y(y4), .zf(zf4), .cf(cf4), .of(of4)
    );

    alu_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n32), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .m(m32), .out_valid(ov32), .y(y32), .zf(zf32), .cf(cf32), .of(of32)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] y;
        logic        zf;
        logic        cf;
        logic        of;
    } res_t;

    // Reference: plain integer arithmetic on unsigned/signed interpretations of the operands.
    function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] m);
        res_t r;
        longint unsigned mask, ua, ub, v;
        longint sa, sb, sr, hi, lo;
        int sh;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        sa   = ((ua >> (w - 1)) & 64'd1) != 0 ? longint'(ua) - longint'(mask) - 1 : longint'(ua);
        sb   = ((ub >> (w - 1)) & 64'd1) != 0 ? longint'(ub) - longint'(mask) - 1 : longint'(ub);
        hi   = (longint'(1) << (w - 1)) - 1;
        lo   = -(longint'(1) << (w - 1));
        sh   = int'(ub % longint'(w));
        r.cf = 1'b0;
        r.of = 1'b0;
        v    = 0;
        case (m)
            ALU_ADD: begin
                v = ua + ub; r.cf = (v >> w) != 0; sr = sa + sb; r.of = (sr > hi) || (sr < lo);
            end
            ALU_SUB: begin
                v = ua - ub; r.cf = ua < ub; sr = sa - sb; r.of = (sr > hi) || (sr < lo);
            end
            ALU_AND:  v = ua & ub;
            ALU_OR:   v = ua | ub;
            ALU_XOR:  v = ua ^ ub;
            ALU_SLT:  v = (sa < sb) ? 1 : 0;
            ALU_SLTU: v = (ua < ub) ? 1 : 0;
            ALU_SLL:  v = ua << sh;
            ALU_SRL:  v = ua >> sh;
            ALU_SRA:  v = longint'(sa >>> sh);
            ALU_MUL: begin
                v = ua * ub; r.cf = (v >> w) != 0;
            end
            default:  v = 0;
        endcase
        r.y  = 32'(v & mask);
        r.zf = (r.y == 32'd0);
        return r;
    endfunction

    typedef struct {
        logic [3:0] m;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] y;
        logic       zf;
        logic       cf;
        logic       of;
    } vec_t;

    vec_t vt[14];
    res_t exp_q[$];

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hffff_ffff;
            2:       return 32'h8000_0000;
            3:       return 32'h7fff_ffff;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk_reset4(input string tag);
        chk({tag, "_out_valid"}, 64'(ov4), 64'd0);
        chk({tag, "_in_ready"}, 64'(ir4), 64'd1);
        chk({tag, "_y"}, 64'(y4), 64'd0);
        chk({tag, "_zf"}, 64'(zf4), 64'd1);
        chk({tag, "_cf"}, 64'(cf4), 64'd0);
        chk({tag, "_of"}, 64'(of4), 64'd0);
    endtask

    // Stream monitor for the WIDTH=32 instance; results must arrive in acceptance order.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (ov32 === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_unexpected_out_valid: got y=%0h with no result pending", y32);
                end else begin
                    e = exp_q.pop_front();
                    chk("rand_y", 64'(y32), 64'(e.y));
                    chk("rand_zf", 64'(zf32), 64'(e.zf));
                    chk("rand_cf", 64'(cf32), 64'(e.cf));
                    chk("rand_of", 64'(of32), 64'(e.of));
                end
            end
        end
    end

    initial begin
        int lows, got, pulses, waited;

        vt[0]  = '{ALU_ADD,  4'h3, 4'hC, 4'hF, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{ALU_ADD,  4'h8, 4'hD, 4'h5, 1'b0, 1'b1, 1'b1};
        vt[2]  = '{ALU_SUB,  4'h7, 4'h7, 4'h0, 1'b1, 1'b0, 1'b0};
        vt[3]  = '{ALU_SUB,  4'h8, 4'h7, 4'h1, 1'b0, 1'b0, 1'b1};
        vt[4]  = '{ALU_SUB,  4'h3, 4'hE, 4'h5, 1'b0, 1'b1, 1'b0};
        vt[5]  = '{ALU_SLT,  4'h8, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{ALU_SLTU, 4'h8, 4'h1, 4'h0, 1'b1, 1'b0, 1'b0};
        vt[7]  = '{ALU_SRA,  4'h8, 4'h2, 4'hE, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{ALU_SRL,  4'h8, 4'h2, 4'h2, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{4'd15,    4'h9, 4'h6, 4'h0, 1'b1, 1'b0, 1'b0};
        vt[10] = '{ALU_AND,  4'hC, 4'hA, 4'h8, 1'b0, 1'b0, 1'b0};
        vt[11] = '{ALU_OR,   4'hC, 4'hA, 4'hE, 1'b0, 1'b0, 1'b0};
        vt[12] = '{ALU_XOR,  4'hC, 4'hA, 4'h6, 1'b0, 1'b0, 1'b0};
        vt[13] = '{ALU_SLL,  4'h3, 4'h7, 4'h8, 1'b0, 1'b0, 1'b0};

        rst_n4 = 1'b0; iv4 = 1'b0; a4 = '0; b4 = '0; m4 = '0;
        rst_n32 = 1'b0; iv32 = 1'b0; a32 = '0; b32 = '0; m32 = '0;
        repeat (2) @(negedge clk);
        chk_reset4("reset");
        chk("reset32_y", 64'(y32), 64'd0);
        chk("reset32_zf", 64'(zf32), 64'd1);
        chk("reset32_in_ready", 64'(ir32), 64'd1);
        rst_n4 = 1'b1;
        rst_n32 = 1'b1;

        // Back-to-back directed vectors: each result must appear one cycle after acceptance.
        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            m4 = vt[i].m; a4 = vt[i].a; b4 = vt[i].b; iv4 = 1'b1;
            chk($sformatf("vec%0d_in_ready", i), 64'(ir4), 64'd1);
            @(negedge clk);
            chk($sformatf("vec%0d_out_valid", i), 64'(ov4), 64'd1);
            chk($sformatf("vec%0d_y", i), 64'(y4), 64'(vt[i].y));
            chk($sformatf("vec%0d_zf", i), 64'(zf4), 64'(vt[i].zf));
            chk($sformatf("vec%0d_cf", i), 64'(cf4), 64'(vt[i].cf));
            chk($sformatf("vec%0d_of", i), 64'(of4), 64'(vt[i].of));
        end
        iv4 = 1'b0;
        @(negedge clk);
        chk("idle_out_valid", 64'(ov4), 64'd0);
        chk("hold_y", 64'(y4), 64'h8);

        // MUL 6*3 with an ADD held on in_valid throughout.
        m4 = ALU_MUL; a4 = 4'h6; b4 = 4'h3; iv4 = 1'b1;
        @(negedge clk);
        m4 = ALU_ADD; a4 = 4'h3; b4 = 4'h4;
        lows = 0;
        got  = 0;
        for (int k = 1; k <= 10 && got == 0; k++) begin
            if (ov4 === 1'b1) begin
                got = k;
                chk("mul_y", 64'(y4), 64'h2);
                chk("mul_cf", 64'(cf4), 64'd1);
                chk("mul_zf", 64'(zf4), 64'd0);
                chk("mul_of", 64'(of4), 64'd0);
                chk("mul_in_ready_at_result", 64'(ir4), 64'd1);
            end else begin
                if (ir4 === 1'b0) lows++;
                @(negedge clk);
            end
        end
        chk("mul_latency", 64'(got), 64'd5);
        chk("mul_in_ready_low_cycles", 64'(lows), 64'd4);
        @(negedge clk);
        iv4 = 1'b0;
        chk("held_add_out_valid", 64'(ov4), 64'd1);
        chk("held_add_y", 64'(y4), 64'h7);

        // Reset two cycles into a MUL, with an ADD presented during reset.
        m4 = ALU_MUL; a4 = 4'h5; b4 = 4'h5; iv4 = 1'b1;
        @(negedge clk);
        iv4 = 1'b0;
        @(negedge clk);
        rst_n4 = 1'b0;
        m4 = ALU_ADD; a4 = 4'h5; b4 = 4'h5; iv4 = 1'b1;
        @(negedge clk);
        chk_reset4("midmul_reset");
        rst_n4 = 1'b1;
        @(negedge clk);
        iv4 = 1'b0;
        chk("post_reset_add_out_valid", 64'(ov4), 64'd1);
        chk("post_reset_add_y", 64'(y4), 64'hA);
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (ov4 === 1'b1) pulses++;
        end
        chk("abandoned_mul_pulses", 64'(pulses), 64'd0);

        // WIDTH = 32 random stream with random idle gaps.
        for (int i = 0; i < 1000; i++) begin
            iv32 = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            a32 = pick();
            b32 = pick();
            m32 = 4'($urandom_range(0, 15));
            iv32 = 1'b1;
            waited = 0;
            while (ir32 !== 1'b1 && waited < 100) begin
                @(negedge clk);
                waited++;
            end
            if (ir32 !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL rand_in_ready_timeout: op %0d still not ready after %0d cycles",
                         i, waited);
            end else begin
                exp_q.push_back(model(32, a32, b32, m32));
            end
            @(negedge clk);
        end
        iv32 = 1'b0;
        repeat (60) @(negedge clk);
        chk("rand_pending_results", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
